// File: rtl/ls_pkg.sv
// Shared definitions for the load/store memory responder.
// Holds the size encodings, FSM state type and the byte-lane extract/merge helpers.
// Used by the responder top and the testbench.
package ls_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Pull the addressed field out of a little-endian word, right-justify it and
  // extend it. Word accesses ignore sgn; an illegal size yields zero.
  function automatic logic [31:0] lane_extract(input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    r = '0;
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      SZ_WORD: r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Overlay the low bytes of wdata onto the addressed lanes of the old word.
  function automatic logic [31:0] lane_merge(input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic [31:0] old,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = old;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      SZ_WORD: r = wdata;
      default: r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_mem_responder_if.sv
// Load/store request/response bus between the processor memory stage and the responder.
// master: processor side (drives req_*, resp_ready); slave: responder side.
// Both channels are valid/ready handshakes; only one request is in flight at a time.
interface load_store_mem_responder_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ls_mem_array.sv
// Single-port synchronous DEPTHx32 word storage, read-first on a same-edge write.
// Ports: clk, we (word write enable), idx (word index), wdata, rdata (registered read).
// Contents are never reset.
module ls_mem_array #(
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/load_store_mem_responder.sv
// Data-memory responder for the load/store unit: byte/half/word loads and stores
// with sign/zero extension, alignment/size/range error reporting, LATENCY-cycle access.
// Ports: clk, reset (async active-low), bus (slave side of the request/response interface).
module load_store_mem_responder
  import ls_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic clk,
  input  logic reset,
  load_store_mem_responder_if.slave bus
);

  localparam int IW = $clog2(DEPTH);

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_sgn;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [31:0]   resp_rdata_q;
  logic          resp_err_q;

  logic          accept;
  logic          access;
  logic          err;
  logic [IW-1:0] mem_idx;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // Error checks work on the latched request, evaluated at access time.
  assign err = (lat_size == 2'b11)
             || ((lat_size == SZ_HALF) && lat_addr[0])
             || ((lat_size == SZ_WORD) && (lat_addr[1:0] != 2'b00))
             || (lat_addr[AW-1:2] >= (AW-2)'(DEPTH));

  // The array reads every cycle. In IDLE it is pointed at the incoming address so
  // that with LATENCY=1 the word is already registered on the access edge.
  assign mem_idx   = (state == ST_IDLE) ? bus.req_addr[IW+1:2] : lat_addr[IW+1:2];
  assign mem_we    = access && lat_we && !err;
  assign mem_wdata = lane_merge(lat_size, lat_addr[1:0], mem_rdata, lat_wdata);

  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    access         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= 4'd0;
      lat_we       <= 1'b0;
      lat_size     <= SZ_BYTE;
      lat_sgn      <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= 4'(LATENCY - 1);
        lat_we    <= bus.req_we;
        lat_size  <= bus.req_size;
        lat_sgn   <= bus.req_signed;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        resp_err_q   <= err;
        resp_rdata_q <= (err || lat_we) ? 32'd0
                      : lane_extract(lat_size, lat_addr[1:0], lat_sgn, mem_rdata);
      end else if ((state == ST_RESP) && bus.resp_ready) begin
        resp_err_q   <= 1'b0;
        resp_rdata_q <= 32'd0;
      end
    end
  end

  ls_mem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_load_store_mem_responder.sv
// Scoreboard bench for load_store_mem_responder: directed requests push expected
// responses into a queue; a monitor pops and compares on each response handshake.
module tb_load_store_mem_responder;
  import ls_pkg::*;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int AW      = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_mem_responder_if #(.AW(AW)) bus();

  load_store_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .AW      (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a response handshake completes on the posedge following a negedge
  // where resp_valid and resp_ready are both high.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (reset && bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got rdata %h err %b, expected no response",
                   bus.resp_rdata, bus.resp_err);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e[31:0]);
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, e[32]});
        end
      end
    end
  end

  // All driving happens 1 time unit after a posedge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit push, input logic [31:0] er, input logic ee);
    int t = 0;
    while (!bus.req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: got req_ready 0 expected 1");
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    if (push) exp_q.push_back({ee, er});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!bus.resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
    int n;
    issue(we, sz, sg, a, wd, 1'b1, er, ee);
    wait_resp(n);
    check("latency", n, LATENCY);
    @(posedge clk); #1;
    check("req_ready_after_hs", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = SZ_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    #2;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Word / byte / halfword traffic
    do_req(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    do_req(1, SZ_BYTE, 0, 32'h12, 32'h0000005A, 32'h0, 0);
    do_req(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDE5ABEEF, 0);
    do_req(0, SZ_WORD, 1, 32'h10, 32'h0, 32'hDE5ABEEF, 0);
    do_req(0, SZ_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    do_req(0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h000000DE, 0);
    do_req(0, SZ_BYTE, 1, 32'h12, 32'h0, 32'h0000005A, 0);
    do_req(0, SZ_HALF, 1, 32'h12, 32'h0, 32'hFFFFDE5A, 0);
    do_req(1, SZ_WORD, 0, 32'h20, 32'h00000000, 32'h0, 0);
    do_req(1, SZ_HALF, 0, 32'h20, 32'h12348001, 32'h0, 0);
    do_req(0, SZ_HALF, 1, 32'h20, 32'h0, 32'hFFFF8001, 0);
    do_req(0, SZ_HALF, 0, 32'h20, 32'h0, 32'h00008001, 0);

    // Errors
    do_req(0, SZ_WORD, 0, 32'h22, 32'h0, 32'h0, 1);
    do_req(1, SZ_HALF, 0, 32'h21, 32'h0000FFFF, 32'h0, 1);
    do_req(0, SZ_WORD, 0, 32'h20, 32'h0, 32'h00008001, 0);
    do_req(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
    do_req(0, SZ_WORD, 0, DEPTH * 4, 32'h0, 32'h0, 1);
    do_req(1, SZ_WORD, 0, DEPTH * 4, 32'h55555555, 32'h0, 1);

    // Backpressure: hold resp_ready low for 5 cycles with a stray request pulse
    bus.resp_ready = 1'b0;
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, 1'b1, 32'hDE5ABEEF, 0);
    wait_resp(n);
    check("bp_latency", n, LATENCY);
    bus.req_we    = 1'b1;
    bus.req_size  = SZ_WORD;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h11111111;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.req_valid = 1'b0;
      check("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("bp_resp_rdata", bus.resp_rdata, 32'hDE5ABEEF);
      check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    check("bp_resp_valid_drop", {31'd0, bus.resp_valid}, 32'd0);
    check("bp_resp_rdata_clr", bus.resp_rdata, 32'd0);
    do_req(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDE5ABEEF, 0);

    // Reset during WAIT of a load
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, 1'b0, 32'h0, 0);
    check("wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mid_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("mid_rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("mid_rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_req(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDE5ABEEF, 0);

    // Reset during WAIT of a store: the store must not commit
    do_req(1, SZ_WORD, 0, 32'h30, 32'h00000000, 32'h0, 0);
    issue(1, SZ_WORD, 0, 32'h30, 32'hAAAAAAAA, 1'b0, 32'h0, 0);
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_req(0, SZ_WORD, 0, 32'h30, 32'h0, 32'h00000000, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_mem_responder.md
Name: load_store_mem_responder

Overview:
- Data-memory responder for the processor's load/store unit: the memory end of the load/store request interface the processor drives.
- Accepts one request at a time and models configurable access latency.
- Supports byte, halfword and word loads and stores, with sign/zero extension and alignment/range error reporting.
- Sits between the processor's memory stage and an internal word-addressed storage array.

Parameters:
- DEPTH, 256: number of 32-bit words in storage; power of two, at least 4.
- LATENCY, 2: cycles from request acceptance to response; range 1..15.
- AW, 32: request address width in bits.

Ports:
- clk  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data; the low bytes are used for sub-word stores.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load result; 0 for stores and for errors.
- resp_err  out  1  misaligned address, illegal size, or out-of-range address.

Behaviour:
- Reset state (reset=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Storage contents are not affected by reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted on an edge where req_valid=1.
  - On acceptance, latch we/size/signed/addr/wdata, load counter=LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge.
  - On the edge where the counter equals 0: perform the access, drive resp_*, go to RESP.
  - Consequence: a request accepted at edge N has resp_valid=1 after edge N+LATENCY.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until the handshake.
  - On an edge where resp_ready=1: resp_valid→0, resp_rdata→0, resp_err→0, go to IDLE.
  - No back-to-back overlap: a new request can be accepted at the earliest one edge after the response handshake.
- Error checks:
  - Misaligned: halfword with addr[0]≠0, or word with addr[1:0]≠0.
  - Illegal size: req_size=11.
  - Out of range: addr[AW-1:2] ≥ DEPTH.
  - On any error: resp_err=1, resp_rdata=0, storage unchanged.
- Byte lanes are little-endian. Word index = addr[log2(DEPTH)+1:2].
  - Byte: lane addr[1:0].
  - Halfword: lanes {addr[1],1},{addr[1],0}.
- Store:
  - Byte writes wdata[7:0] into its lane; halfword writes wdata[15:0]; word writes all 32 bits.
  - Other lanes are unchanged.
  - The write commits on the edge that enters RESP.
  - resp_rdata=0, resp_err=0.
- Load:
  - Selected bytes are right-justified.
  - If req_signed=1, the upper bits are copied from the selected field's MSB; otherwise they are zero.
  - Word loads ignore req_signed.
- Reset asserted mid-transaction: the transaction is abandoned. A store commits only if its RESP-entry edge occurred before reset asserted.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package (ls_pkg):
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding.
  - Lane-extract function (size, offset, signed, word → 32-bit result).
  - Lane-merge function (size, offset, old word, wdata → new word).
- One natural sub-module: ls_mem_array, a single-port synchronous DEPTH×32 storage with a word write-enable.
- FSM, counter and lane logic stay in the top module.

Test Plan:
- Word store/load, LATENCY=2: store 0xDEADBEEF to addr 0x10, then load word from 0x10.
  - resp_rdata=0xDEADBEEF, resp_err=0.
  - resp_valid rises exactly 2 edges after each acceptance.
- Byte lanes: after the store above, store byte 0x5A to 0x12.
  - Word load from 0x10 → 0xDE5ABEEF.
  - Signed byte load from 0x13 → 0xFFFFFFDE; unsigned → 0x000000DE.
- Halfword: store half 0x8001 to 0x20.
  - Signed half load from 0x20 → 0xFFFF8001; unsigned → 0x00008001.
- Errors:
  - Word load from 0x22 → resp_err=1, resp_rdata=0.
  - Half store to 0x21 → resp_err=1, and a later word load from 0x20 shows unchanged data.
  - req_size=11 → resp_err=1.
  - addr=DEPTH*4 → resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles.
  - resp_valid and resp_rdata stay stable, req_ready=0, and a req_valid pulse during this time is ignored.
  - After resp_ready=1, req_ready returns to 1 on the next edge.
- Reset mid-WAIT: assert reset during WAIT of a load.
  - All outputs go to their reset values immediately (asynchronously).
  - After release, a new request completes normally.
